// File: rtl/wam_round_scheduler_if.sv
// ----------------------------------------------------------------------------
// wam_round_scheduler_if
//   Bundle between the game-mode/difficulty logic, the keypad/LED controllers
//   and wam_round_scheduler.
//   master : drives control, timing and keypad inputs; observes score outputs
//   slave  : the scheduler itself
//   Control  : start, abort, load_seed, seed
//   Timing   : between_cycles, on_cycles, total_rounds, deathmatch
//   Keypad   : key_valid, key_idx
//   Outputs  : lights, hits, misses, rounds_done, busy, done, lost
// ----------------------------------------------------------------------------
interface wam_round_scheduler_if #(
  parameter int CNT_W = 28,
  parameter int RND_W = 6
);
  logic             start;
  logic             abort;
  logic             load_seed;
  logic [15:0]      seed;
  logic [CNT_W-1:0] between_cycles;
  logic [CNT_W-1:0] on_cycles;
  logic [RND_W-1:0] total_rounds;
  logic             deathmatch;
  logic             key_valid;
  logic [3:0]       key_idx;
  logic [8:0]       lights;
  logic [RND_W-1:0] hits;
  logic [RND_W-1:0] misses;
  logic [RND_W-1:0] rounds_done;
  logic             busy;
  logic             done;
  logic             lost;

  modport master (
    output start, abort, load_seed, seed, between_cycles, on_cycles,
           total_rounds, deathmatch, key_valid, key_idx,
    input  lights, hits, misses, rounds_done, busy, done, lost
  );

  modport slave (
    input  start, abort, load_seed, seed, between_cycles, on_cycles,
           total_rounds, deathmatch, key_valid, key_idx,
    output lights, hits, misses, rounds_done, busy, done, lost
  );
endinterface

// File: rtl/wam_round_scheduler.sv
// ----------------------------------------------------------------------------
// wam_round_scheduler
//   Runs one whack-a-mole game: per round waits a gap, lights a pseudo-random
//   mole (1 of 9) for an on-window and scores the keypad response.
//   Ports:
//     clk    : system clock
//     resetn : asynchronous active-low reset
//     bus    : wam_round_scheduler_if.slave (control, timing, keypad, score)
//   Optional feature macro: WAM_WRONG_KEY_PENALTY_EN
//     defined   -> a wrong key during ON ends the round as a miss
//     undefined -> wrong keys are ignored
// ----------------------------------------------------------------------------
module wam_round_scheduler #(
  parameter int          CNT_W    = 28,
  parameter int          RND_W    = 6,
  parameter logic [15:0] SEED_DEF = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  resetn,
  wam_round_scheduler_if.slave  bus
);

`ifdef WAM_WRONG_KEY_PENALTY_EN
  localparam bit WRONG_KEY_PENALTY = 1'b1;
`else
  localparam bit WRONG_KEY_PENALTY = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_GAP, S_ON, S_SCORE, S_DONE} state_t;

  state_t           r_state,  w_state_nxt;
  logic [CNT_W-1:0] r_timer,  w_timer_nxt;
  logic [15:0]      r_lfsr,   w_lfsr_nxt;
  logic [3:0]       r_mole,   w_mole_nxt;
  logic [8:0]       r_lights, w_lights_nxt;
  logic [RND_W-1:0] r_hits,   w_hits_nxt;
  logic [RND_W-1:0] r_misses, w_misses_nxt;
  logic [RND_W-1:0] r_rounds, w_rounds_nxt;
  logic             r_lost,   w_lost_nxt;
  logic             r_hit,    w_hit_nxt;

  logic [15:0]      w_lfsr_step;
  logic [3:0]       w_step_v;
  logic [3:0]       w_step_mole;
  logic [15:0]      w_seed_val;
  logic             w_key_hit;
  logic             w_key_wrong;
  logic [RND_W-1:0] w_target;
  logic             w_last_round;

  function automatic logic [RND_W-1:0] sat_inc(input logic [RND_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Fibonacci LFSR, taps 16,14,13,11 -> bit indices 15,13,12,10, shifting left.
  assign w_lfsr_step = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  assign w_step_v    = w_lfsr_step[3:0];
  assign w_step_mole = (w_step_v < 4'd9) ? w_step_v : w_step_v - 4'd9;
  // An all-zero seed would lock the LFSR up.
  assign w_seed_val  = (bus.seed == 16'd0) ? SEED_DEF : bus.seed;

  assign w_key_hit    = bus.key_valid && (bus.key_idx == r_mole);
  assign w_key_wrong  = bus.key_valid && (bus.key_idx != r_mole);
  assign w_target     = (bus.total_rounds == '0) ? RND_W'(1) : bus.total_rounds;
  // One extra bit so the +1 cannot wrap when rounds_done is all-ones.
  assign w_last_round = ({1'b0, r_rounds} + 1'b1) >= {1'b0, w_target};

  // NOTE: every next-state value gets a default first so no path leaves it
  // unassigned; otherwise this process would infer latches.
  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_lfsr_nxt   = r_lfsr;
    w_mole_nxt   = r_mole;
    w_lights_nxt = r_lights;
    w_hits_nxt   = r_hits;
    w_misses_nxt = r_misses;
    w_rounds_nxt = r_rounds;
    w_lost_nxt   = r_lost;
    w_hit_nxt    = r_hit;

    if (bus.abort) begin
      // Counters are left alone so the last score stays on display.
      w_state_nxt  = S_IDLE;
      w_lights_nxt = '0;
      w_timer_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (r_state == S_IDLE && bus.load_seed) w_lfsr_nxt = w_seed_val;
          if (bus.start) begin
            w_state_nxt  = S_GAP;
            w_timer_nxt  = '0;
            w_hits_nxt   = '0;
            w_misses_nxt = '0;
            w_rounds_nxt = '0;
            w_lost_nxt   = 1'b0;
          end
        end
        S_GAP: begin
          if (r_timer == bus.between_cycles) begin
            w_state_nxt  = S_ON;
            w_timer_nxt  = '0;
            w_lfsr_nxt   = w_lfsr_step;
            w_mole_nxt   = w_step_mole;
            w_lights_nxt = 9'd1 << w_step_mole;
          end else begin
            w_timer_nxt = r_timer + 1'b1;
          end
        end
        S_ON: begin
          // A hit outranks a timeout landing on the same cycle.
          if (w_key_hit) begin
            w_state_nxt  = S_SCORE;
            w_hit_nxt    = 1'b1;
            w_lights_nxt = '0;
          end else if ((r_timer == bus.on_cycles) || (WRONG_KEY_PENALTY && w_key_wrong)) begin
            w_state_nxt  = S_SCORE;
            w_hit_nxt    = 1'b0;
            w_lights_nxt = '0;
          end else begin
            w_timer_nxt = r_timer + 1'b1;
          end
        end
        S_SCORE: begin
          if (r_hit) w_hits_nxt   = sat_inc(r_hits);
          else       w_misses_nxt = sat_inc(r_misses);
          w_rounds_nxt = sat_inc(r_rounds);
          w_timer_nxt  = '0;
          if (w_last_round || (bus.deathmatch && !r_hit)) begin
            w_state_nxt = S_DONE;
            w_lost_nxt  = bus.deathmatch && !r_hit;
          end else begin
            w_state_nxt = S_GAP;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_lfsr   <= SEED_DEF;
      r_mole   <= '0;
      r_lights <= '0;
      r_hits   <= '0;
      r_misses <= '0;
      r_rounds <= '0;
      r_lost   <= 1'b0;
      r_hit    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_lfsr   <= w_lfsr_nxt;
      r_mole   <= w_mole_nxt;
      r_lights <= w_lights_nxt;
      r_hits   <= w_hits_nxt;
      r_misses <= w_misses_nxt;
      r_rounds <= w_rounds_nxt;
      r_lost   <= w_lost_nxt;
      r_hit    <= w_hit_nxt;
    end
  end

  assign bus.lights      = r_lights;
  assign bus.hits        = r_hits;
  assign bus.misses      = r_misses;
  assign bus.rounds_done = r_rounds;
  assign bus.busy        = (r_state == S_GAP) || (r_state == S_ON) || (r_state == S_SCORE);
  assign bus.done        = (r_state == S_DONE);
  assign bus.lost        = r_lost;

endmodule

// File: tb/tb_wam_round_scheduler.sv
// ----------------------------------------------------------------------------
// tb_wam_round_scheduler
//   Directed bench for wam_round_scheduler. Stimulus pushes the expected mole
//   LEDs and end-of-game score into queues; a negedge monitor pops and
//   compares whenever lights turn on or done rises.
//   Hand-derived LFSR results (left shift, feedback b15^b13^b12^b10):
//     0xACE1 -> 0x59C3 (mole 3) -> 0xB387 (mole 7)
//     0x0001 -> 0x0002 (mole 2) -> 0x0004 (mole 4)
//     0x0005 -> 0x000A (v=10, mole 1)
// ----------------------------------------------------------------------------
module tb_wam_round_scheduler;
  localparam int CNT_W = 28;
  localparam int RND_W = 6;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  wam_round_scheduler_if #(.CNT_W(CNT_W), .RND_W(RND_W)) bus ();

  wam_round_scheduler #(.CNT_W(CNT_W), .RND_W(RND_W), .SEED_DEF(16'hACE1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0]  mole_q[$];
  logic [18:0] end_q[$];   // {hits, misses, rounds_done, lost}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] score(input int h, input int m, input int r, input bit l);
    return {RND_W'(h), RND_W'(m), RND_W'(r), l};
  endfunction

  // ---------------- monitor ----------------
  logic [8:0] prev_lights = '0;
  logic       prev_done   = 1'b0;
  always @(negedge clk) begin
    if (resetn) begin
      if (bus.lights != 9'd0 && prev_lights == 9'd0) begin
        if (mole_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL mole_unexpected: got 0x%0h expected none", bus.lights);
        end else begin
          check("mole", 32'(bus.lights), 32'(mole_q.pop_front()));
        end
      end
      if (bus.done && !prev_done) begin
        if (end_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL end_unexpected: got 0x%0h expected none",
                   {bus.hits, bus.misses, bus.rounds_done, bus.lost});
        end else begin
          check("end_score", 32'({bus.hits, bus.misses, bus.rounds_done, bus.lost}),
                32'(end_q.pop_front()));
        end
      end
    end
    prev_lights = bus.lights;
    prev_done   = bus.done;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
  endtask

  task automatic pulse_abort();
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
  endtask

  task automatic load(input logic [15:0] s);
    bus.seed = s; bus.load_seed = 1'b1; tick(); bus.load_seed = 1'b0;
  endtask

  task automatic press(input logic [3:0] k);
    bus.key_valid = 1'b1; bus.key_idx = k; tick(); bus.key_valid = 1'b0;
  endtask

  task automatic wait_lights(input string name, output int n);
    n = 0;
    while (bus.lights == 9'd0 && n < 100) begin tick(); n++; end
    check(name, 32'(bus.lights != 9'd0), 32'd1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!bus.done && n < 500) begin tick(); n++; end
    check(name, 32'(bus.done), 32'd1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int n;
    bus.start = 0; bus.abort = 0; bus.load_seed = 0; bus.seed = '0;
    bus.between_cycles = CNT_W'(3); bus.on_cycles = CNT_W'(4);
    bus.total_rounds = RND_W'(2); bus.deathmatch = 0;
    bus.key_valid = 0; bus.key_idx = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    tick();
    check("reset_state", 32'({bus.lights, bus.hits, bus.misses, bus.rounds_done,
                             bus.busy, bus.done, bus.lost}), 32'd0);

    // 1: two timed-out rounds from the reset seed
    mole_q.push_back(9'h008); mole_q.push_back(9'h080);
    end_q.push_back(score(0, 2, 2, 0));
    pulse_start();
    check("t1_busy_after_start", 32'(bus.busy), 32'd1);
    wait_lights("t1_lit", n);
    check("t1_gap_len", 32'(n), 32'd4);
    n = 0;
    while (bus.lights != 9'd0 && n < 100) begin tick(); n++; end
    check("t1_on_len", 32'(n), 32'd5);
    wait_done("t1_done");
    check("t1_not_busy", 32'(bus.busy), 32'd0);

    // 2: seed 1, hit on the 3rd ON cycle
    pulse_abort();
    load(16'h0001);
    bus.total_rounds = RND_W'(1);
    mole_q.push_back(9'h004); end_q.push_back(score(1, 0, 1, 0));
    pulse_start();
    wait_lights("t2_lit", n);
    tick(); tick();
    press(4'd2);
    check("t2_lights_off", 32'(bus.lights), 32'd0);
    wait_done("t2_done");
    check("t2_hits", 32'(bus.hits), 32'd1);

    // 3: deathmatch ends on first miss; seed 5 exercises the v>=9 fold
    pulse_abort();
    load(16'h0005);
    bus.deathmatch = 1'b1; bus.total_rounds = RND_W'(5);
    mole_q.push_back(9'h002); end_q.push_back(score(0, 1, 1, 1));
    pulse_start();
    wait_done("t3_done");
    bus.deathmatch = 1'b0;

    // 4: hit on the same cycle as the timeout
    pulse_abort();
    load(16'h0001);
    bus.total_rounds = RND_W'(1);
    mole_q.push_back(9'h004); end_q.push_back(score(1, 0, 1, 0));
    pulse_start();
    wait_lights("t4_lit", n);
    repeat (4) tick();
    press(4'd2);
    wait_done("t4_done");

    // 5: abort mid-ON holds counters; next start clears; total 0 acts as 1
    pulse_abort();
    load(16'h0001);
    bus.total_rounds = RND_W'(3);
    mole_q.push_back(9'h004); mole_q.push_back(9'h010);
    pulse_start();
    wait_lights("t5_lit1", n);
    press(4'd2);
    wait_lights("t5_lit2", n);
    pulse_abort();
    check("t5_abort_lights", 32'(bus.lights), 32'd0);
    check("t5_abort_state", 32'({bus.busy, bus.done}), 32'd0);
    check("t5_abort_held", 32'({bus.hits, bus.misses, bus.rounds_done, bus.lost}),
          32'(score(1, 0, 1, 0)));
    load(16'h0000);
    bus.total_rounds = RND_W'(0);
    mole_q.push_back(9'h008); end_q.push_back(score(0, 1, 1, 0));
    pulse_start();
    check("t5_cleared", 32'({bus.hits, bus.misses, bus.rounds_done, bus.lost}), 32'd0);
    wait_done("t5_done");

    // 6: wrong key during ON
    pulse_abort();
    load(16'h0001);
    bus.total_rounds = RND_W'(1);
    mole_q.push_back(9'h004);
`ifdef WAM_WRONG_KEY_PENALTY_EN
    end_q.push_back(score(0, 1, 1, 0));
`else
    end_q.push_back(score(1, 0, 1, 0));
`endif
    pulse_start();
    wait_lights("t6_lit", n);
    press(4'd5);
`ifdef WAM_WRONG_KEY_PENALTY_EN
    check("t6_wrong_ends", 32'(bus.lights), 32'd0);
`else
    check("t6_wrong_ignored", 32'(bus.lights), 32'h004);
    press(4'd2);
    check("t6_hit_after_wrong", 32'(bus.lights), 32'd0);
`endif
    wait_done("t6_done");

    repeat (3) tick();
    check("mole_q_empty", 32'(mole_q.size()), 32'd0);
    check("end_q_empty", 32'(end_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wam_round_scheduler.md
Name: wam_round_scheduler

Overview:
Sequences one whack-a-mole game from start to finish. For each round it:
- waits a gap,
- picks a pseudo-random mole (1 of 9 LEDs),
- lights it for an on-window,
- scores the keypad response as a hit or a miss.

It sits between the game-mode/difficulty logic (which supplies timings, round count and mode) and the LED/keypad controllers. It reports hits, misses and game end.

Parameters:
CNT_W, 28, width of the gap and on-window timers (2 s at 50 MHz fits).
RND_W, 6, width of round, hit and miss counters.
SEED_DEF, 16'hACE1, LFSR value after reset.

Ports:
clk  in  1  system clock (50 MHz)
resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins or restarts a game
abort  in  1  level; forces IDLE while high
load_seed  in  1  loads seed into LFSR (honoured in IDLE only)
seed  in  16  LFSR seed; value 0 is replaced by SEED_DEF
between_cycles  in  CNT_W  gap length minus 1
on_cycles  in  CNT_W  on-window length minus 1
total_rounds  in  RND_W  rounds per game; 0 treated as 1
deathmatch  in  1  first miss ends the game
key_valid  in  1  one-cycle keypress strobe from keypad controller
key_idx  in  4  pressed key, 0-8 (9-15 never match)
lights  out  9  one-hot mole LED, registered
hits  out  RND_W  hit count
misses  out  RND_W  miss count
rounds_done  out  RND_W  completed rounds
busy  out  1  high in GAP, ON and SCORE
done  out  1  high in DONE
lost  out  1  set in DONE when a deathmatch miss ended the game

Behaviour:
- Reset (async, resetn=0): state IDLE; lights=0, counters=0, busy=0, done=0, lost=0, LFSR=SEED_DEF.
- States: IDLE, GAP, ON, SCORE, DONE. All inputs sampled on posedge clk.
- IDLE
  - load_seed=1 loads the LFSR.
  - start=1 clears hits, misses, rounds_done and lost, and moves to GAP with the timer at 0.
- GAP
  - Timer increments each cycle; when timer==between_cycles the block moves to ON (gap = between_cycles+1 cycles).
  - On exit: the LFSR steps once (Fibonacci, taps 16,14,13,11), the mole index is taken, and lights is set to one-hot(mole) starting the first ON cycle.
  - Mole index: v=lfsr[3:0]; mole = v<9 ? v : v-9.
- ON
  - Timer increments from 0.
  - key_valid with key_idx==mole gives a hit → SCORE.
  - Timer==on_cycles with no hit gives a miss → SCORE.
  - A hit and timeout in the same cycle count as a hit.
  - key_valid with a wrong index is ignored.
  - lights clears on entry to SCORE.
- SCORE (1 cycle)
  - Increments hits or misses, and rounds_done.
  - Goes to DONE if rounds_done+1 >= max(total_rounds,1), or if deathmatch=1 and the round was a miss (then lost=1); otherwise goes to GAP.
- DONE
  - Counters and lost are held; busy=0, done=1.
  - start begins a new game exactly as from IDLE.
- abort=1 in any state: next edge goes to IDLE, lights=0; counters are held for display until the next start.
- start while busy is ignored.
- key_valid outside ON is ignored.
- total_rounds, timing inputs and deathmatch are sampled live; changing them mid-game takes effect at the next compare.
- Counters saturate at all-ones.
- Latency: start to GAP is 1 cycle; the hit key_valid cycle to lights=0 is 1 cycle.

Optional Feature:
WAM_WRONG_KEY_PENALTY_EN
- Defined: key_valid in ON with key_idx!=mole is scored as a miss and ends the round (→ SCORE). In deathmatch it ends the game with lost=1.
- Undefined: wrong keys are ignored, as specified above.

Test Plan:
1. Reset, then start with between=3, on=4, total_rounds=2, no keys → each round has 4 GAP + 5 ON cycles, misses=2, hits=0, done=1, lost=0.
2. Seed 16'h0001 loaded in IDLE, start → lights equals one-hot of the mole computed by a reference LFSR model; press the matching key_idx on the 3rd ON cycle → lights=0 next cycle, hits=1.
3. deathmatch=1, total_rounds=5, first round times out → DONE after round 1, lost=1, rounds_done=1.
4. Hit and timeout in the same cycle → hits increments, misses unchanged.
5. abort asserted mid-ON → IDLE next edge, lights=0, counters held; a later start clears them to 0.
6. Wrong key in ON → ignored (round still hittable); with WAM_WRONG_KEY_PENALTY_EN → misses=1 and lights=0 next cycle.
